msdap_output_capture: RTL and testbench

Downstream receiver for the MSDAP serial outputs. Deserializes the two 40-bit result words shifted out on `OutputL`/`OutputR` while `OutReady` is high, checks frame length, and buffers complete left/right word pairs in a small first-word-fall-through FIFO. The FIFO is drained through a valid/ready handshake by the host-side consumer. Runs entirely in the SCLK domain.

---
 rtl/msdap_out_pkg.sv | 18 +
 rtl/outcap_fifo.sv | 63 ++++++
 rtl/msdap_output_capture.sv | 164 ++++++++++++++++
 tb/tb_msdap_output_capture.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/msdap_out_pkg.sv
// Shared types and constants for the MSDAP serial output capture block.
package msdap_out_pkg;

    localparam int unsigned MSDAP_WORD_W = 40;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_WAIT_LOW = 2'd3
    } outcap_state_t;

    typedef struct packed {
        logic [MSDAP_WORD_W-1:0] l;
        logic [MSDAP_WORD_W-1:0] r;
    } result_pair_t;

endpackage

// File: rtl/outcap_fifo.sv
// First-word-fall-through FIFO of left/right result pairs; a pop frees a slot
// for a push in the same cycle, so both complete when full.
module outcap_fifo
    import msdap_out_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  result_pair_t             push_data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output result_pair_t             head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    result_pair_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             pop_acc_c;
    logic             push_acc_c;

    always_comb begin
        empty_o    = (level_q == '0);
        full_o     = (level_q == LVL_W'(DEPTH));
        pop_acc_c  = pop_i && !empty_o;
        push_acc_c = push_i && (!full_o || pop_acc_c);
        level_o    = level_q;
        head_o     = mem_q[rd_ptr_q];
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_acc_c) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_acc_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_acc_c, pop_acc_c})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/msdap_output_capture.sv
// Deserializes MSDAP OutputL/OutputR words framed by OutReady and buffers pairs.
// Optional statistics counters are enabled with MSDAP_OUTCAP_STATS_EN.
module msdap_output_capture
    import msdap_out_pkg::*;
#(
    parameter int unsigned WORD_W = MSDAP_WORD_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     SCLK,
    input  logic                     Reset_n,
    input  logic                     OutputL,
    input  logic                     OutputR,
    input  logic                     OutReady,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W-1:0]        out_data_l,
    output logic [WORD_W-1:0]        out_data_r,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     frame_err
`ifdef MSDAP_OUTCAP_STATS_EN
   ,output logic [15:0]              word_count,
    output logic [7:0]               err_count
`endif
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    outcap_state_t     state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] sh_l_q, sh_l_d;
    logic [WORD_W-1:0] sh_r_q, sh_r_d;
    logic              frame_err_q, frame_err_d;
    logic              overflow_q, overflow_d;

    logic              push_c;
    logic              pop_c;
    logic              fifo_full;
    logic              fifo_empty;
    result_pair_t      push_data;
    result_pair_t      head;

    assign pop_c          = !fifo_empty && out_ready;
    assign push_data.l    = sh_l_q;
    assign push_data.r    = sh_r_q;

    // Next-state and pulse generation.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sh_l_d      = sh_l_q;
        sh_r_d      = sh_r_q;
        frame_err_d = 1'b0;
        overflow_d  = 1'b0;
        push_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (OutReady) begin
                    sh_l_d    = {sh_l_q[WORD_W-2:0], OutputL};
                    sh_r_d    = {sh_r_q[WORD_W-2:0], OutputR};
                    bit_cnt_d = CNT_W'(1);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (OutReady) begin
                    sh_l_d    = {sh_l_q[WORD_W-2:0], OutputL};
                    sh_r_d    = {sh_r_q[WORD_W-2:0], OutputR};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                        state_d = ST_COMMIT;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    state_d     = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                push_c      = 1'b1;
                overflow_d  = fifo_full && !pop_c;
                bit_cnt_d   = '0;
                // OutReady still high here means the burst ran past WORD_W bits.
                frame_err_d = OutReady;
                state_d     = OutReady ? ST_WAIT_LOW : ST_IDLE;
            end
            ST_WAIT_LOW: begin
                if (!OutReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            sh_l_q      <= '0;
            sh_r_q      <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_l_q      <= sh_l_d;
            sh_r_q      <= sh_r_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    outcap_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (SCLK),
        .rst_n       (Reset_n),
        .push_i      (push_c),
        .pop_i       (out_ready),
        .push_data_i (push_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level),
        .head_o      (head)
    );

    assign out_valid  = !fifo_empty;
    assign out_data_l = head.l;
    assign out_data_r = head.r;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

`ifdef MSDAP_OUTCAP_STATS_EN
    logic        accept_c;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [8:0]  err_sum_c;

    // Errors are counted from the registered pulses; both may fire together.
    always_comb begin
        accept_c   = push_c && (!fifo_full || pop_c);
        word_cnt_d = accept_c ? word_cnt_q + 16'(1) : word_cnt_q;
        err_sum_c  = {1'b0, err_cnt_q} + 9'(overflow_q) + 9'(frame_err_q);
        err_cnt_d  = err_sum_c[8] ? 8'hFF : err_sum_c[7:0];
    end

    always_ff @(posedge SCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign word_count = word_cnt_q;
    assign err_count  = err_cnt_q;
`endif

endmodule

// File: tb/tb_msdap_output_capture.sv
// Scoreboard bench for msdap_output_capture: serial bursts in, FIFO pairs out.
module tb_msdap_output_capture;
    import msdap_out_pkg::*;

    localparam int unsigned W     = 40;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             SCLK      = 1'b0;
    logic             Reset_n   = 1'b0;
    logic             OutputL   = 1'b0;
    logic             OutputR   = 1'b0;
    logic             OutReady  = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [W-1:0]     out_data_l;
    logic [W-1:0]     out_data_r;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;
    logic             frame_err;
`ifdef MSDAP_OUTCAP_STATS_EN
    logic [15:0]      word_count;
    logic [7:0]       err_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int ov_seen = 0;
    int fe_seen = 0;
    int exp_ov = 0;
    int exp_fe = 0;
    int exp_words = 0;
    int exp_errs = 0;
    result_pair_t sb[$];

    always #5 SCLK = ~SCLK;

    msdap_output_capture #(
        .WORD_W(W),
        .DEPTH (DEPTH)
    ) dut (
        .SCLK       (SCLK),
        .Reset_n    (Reset_n),
        .OutputL    (OutputL),
        .OutputR    (OutputR),
        .OutReady   (OutReady),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data_l (out_data_l),
        .out_data_r (out_data_r),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_err  (frame_err)
`ifdef MSDAP_OUTCAP_STATS_EN
       ,.word_count (word_count),
        .err_count  (err_count)
`endif
    );

    // Pulse monitor: counts every sampled cycle a pulse output is high.
    always @(negedge SCLK) begin
        if (overflow === 1'b1) ov_seen++;
        if (frame_err === 1'b1) fe_seen++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic note_err();
        if (exp_errs < 255) exp_errs++;
    endtask

    function automatic logic [W-1:0] rnd40();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[W-1:0];
    endfunction

    // Drive one OutReady burst of nbits and update the model.
    task automatic send_burst(input logic [W-1:0] l, input logic [W-1:0] r,
                              input int nbits, input bit pop_commit);
        result_pair_t p;
        result_pair_t gone;
        bit           was_empty;
        p.l = l;
        p.r = r;
        was_empty = (sb.size() == 0) && !pop_commit;
        for (int i = 0; i < nbits; i++) begin
            @(negedge SCLK);
            OutReady = 1'b1;
            if (i < int'(W)) begin
                OutputL = l[W-1-i];
                OutputR = r[W-1-i];
            end else begin
                OutputL = 1'($urandom());
                OutputR = 1'($urandom());
            end
        end
        @(negedge SCLK);
        OutReady = 1'b0;
        OutputL  = 1'b0;
        OutputR  = 1'b0;
        if (nbits == int'(W) && was_empty) check("lat_commit_valid", 64'(out_valid), 64'd0);
        if (nbits >= int'(W)) begin
            if (pop_commit) begin
                check("commit_head_l", 64'(out_data_l), 64'(sb[0].l));
                check("commit_head_r", 64'(out_data_r), 64'(sb[0].r));
                out_ready = 1'b1;
                gone = sb.pop_front();
            end
            if (sb.size() < int'(DEPTH)) begin
                sb.push_back(p);
                exp_words++;
            end else begin
                exp_ov++;
                note_err();
            end
            if (nbits > int'(W)) begin
                exp_fe++;
                note_err();
            end
        end else begin
            exp_fe++;
            note_err();
        end
        @(negedge SCLK);
        out_ready = 1'b0;
        if (nbits == int'(W) && was_empty) check("lat_push_valid", 64'(out_valid), 64'd1);
        repeat (2) @(negedge SCLK);
    endtask

    // Pop everything the model holds, checking order and level.
    task automatic drain_all();
        result_pair_t e;
        while (sb.size() > 0) begin
            check("level", 64'(fifo_level), 64'(sb.size()));
            check("valid", 64'(out_valid), 64'd1);
            check("data_l", 64'(out_data_l), 64'(sb[0].l));
            check("data_r", 64'(out_data_r), 64'(sb[0].r));
            out_ready = 1'b1;
            @(negedge SCLK);
            out_ready = 1'b0;
            e = sb.pop_front();
        end
        check("drained_valid", 64'(out_valid), 64'd0);
        check("drained_level", 64'(fifo_level), 64'd0);
        out_ready = 1'b1;
        @(negedge SCLK);
        out_ready = 1'b0;
        check("empty_pop_level", 64'(fifo_level), 64'd0);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_valid"}, 64'(out_valid), 64'd0);
        check({pfx, "_data_l"}, 64'(out_data_l), 64'd0);
        check({pfx, "_data_r"}, 64'(out_data_r), 64'd0);
        check({pfx, "_level"}, 64'(fifo_level), 64'd0);
        check({pfx, "_overflow"}, 64'(overflow), 64'd0);
        check({pfx, "_frame_err"}, 64'(frame_err), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge SCLK);
        check_reset_values("rst");
        Reset_n = 1'b1;
        repeat (2) @(negedge SCLK);

        // Single burst with boundary bit patterns
        send_burst(40'h80_0000_0001, 40'hFF_FFFF_FFFE, 40, 1'b0);
        check("single_level", 64'(fifo_level), 64'd1);
        drain_all();

        // Fill past depth without draining
        for (int k = 0; k < 5; k++) send_burst(rnd40(), rnd40(), 40, 1'b0);
        check("fill_level", 64'(fifo_level), 64'(DEPTH));
        check("fill_overflow", 64'(ov_seen), 64'(exp_ov));
        drain_all();

        // Full FIFO with a pop in the COMMIT cycle
        for (int k = 0; k < 4; k++) send_burst(rnd40(), rnd40(), 40, 1'b0);
        send_burst(rnd40(), rnd40(), 40, 1'b1);
        check("popfull_level", 64'(fifo_level), 64'(DEPTH));
        check("popfull_overflow", 64'(ov_seen), 64'(exp_ov));
        drain_all();

        // Short burst then a good one
        send_burst(rnd40(), rnd40(), 39, 1'b0);
        send_burst(rnd40(), rnd40(), 40, 1'b0);
        check("short_frame_err", 64'(fe_seen), 64'(exp_fe));
        check("short_level", 64'(fifo_level), 64'd1);
        drain_all();

        // Long burst: word kept, one frame_err
        send_burst(40'h12_3456_789A, 40'hA5_5A5A_A5A5, 41, 1'b0);
        check("long_frame_err", 64'(fe_seen), 64'(exp_fe));
        check("long_level", 64'(fifo_level), 64'd1);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 20; i++) begin
            @(negedge SCLK);
            OutReady = 1'b1;
            OutputL  = 1'($urandom());
            OutputR  = 1'($urandom());
        end
        #2 Reset_n = 1'b0;
        #1 check_reset_values("async_rst");
        sb.delete();
        exp_words = 0;
        exp_errs  = 0;
        @(negedge SCLK);
        Reset_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge SCLK);
            OutputL = 1'($urandom());
            OutputR = 1'($urandom());
        end
        @(negedge SCLK);
        OutReady = 1'b0;
        exp_fe++;
        note_err();
        repeat (3) @(negedge SCLK);
        check("rst_tail_frame_err", 64'(fe_seen), 64'(exp_fe));
        check("rst_tail_level", 64'(fifo_level), 64'd0);

        // Good bursts plus one overflow after reset
        for (int k = 0; k < 5; k++) send_burst(rnd40(), rnd40(), 40, 1'b0);
        drain_all();
`ifdef MSDAP_OUTCAP_STATS_EN
        check("word_count", 64'(word_count), 64'(exp_words));
        check("err_count", 64'(err_count), 64'(exp_errs));
`endif
        check("total_overflow", 64'(ov_seen), 64'(exp_ov));
        check("total_frame_err", 64'(fe_seen), 64'(exp_fe));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
